// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// A fetch_entry_t pairs a fetched word with the PC it was fetched from.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus plus the decode-side handshake.
// The fetch stage takes the master modport; memory and decode sit on the slave side.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// First-word-fall-through buffer of fetch entries with synchronous flush.
// Pointers wrap explicitly at DEPTH so non-power-of-2 depths work.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !flush && (count_reg != '0);
  assign do_push = push && !flush && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head       = mem_reg[rd_ptr_reg];
  assign head_valid = (count_reg != '0);
  assign count      = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests, buffers
// responses for decode, and squashes in-flight work on a redirect.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  instr_fetch_if.master   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0]  resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  fetch_entry_t     head, push_entry;
  logic             head_valid, issue, push, pop;

  // Credits cover both buffered and in-flight words so every response has a slot.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign bus.imem_req  = !rst && !redirect && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign bus.imem_addr = fetch_pc_reg;

  assign issue = bus.imem_req && bus.imem_gnt;
  assign push  = bus.imem_rvalid && (drop_cnt_reg == '0) && !redirect;
  assign pop   = head_valid && bus.instr_ready && !rst && !redirect;
  assign push_entry = '{pc: resp_pc_reg, instr: bus.imem_rdata};

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    drop_cnt_next    = drop_cnt_reg;
    outstanding_next = outstanding_reg + CNT_W'(issue) - CNT_W'(bus.imem_rvalid);
    if (redirect) begin
      fetch_pc_next = align_word(redirect_pc);
      resp_pc_next  = align_word(redirect_pc);
      drop_cnt_next = outstanding_reg - CNT_W'(bus.imem_rvalid);
    end else begin
      if (issue) fetch_pc_next = fetch_pc_reg + PC_STEP;
      if (push)  resp_pc_next  = resp_pc_reg + PC_STEP;
      if (bus.imem_rvalid && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign bus.instr_valid = head_valid && !rst;
  assign bus.instr       = bus.instr_valid ? head.instr : '0;
  assign bus.instr_pc    = bus.instr_valid ? head.pc : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_credit : assert (credit_used <= (CNT_W + 1)'(FIFO_DEPTH));
      a_drop   : assert (drop_cnt_reg <= outstanding_reg);
      a_rvalid : assert (!(bus.imem_rvalid && (outstanding_reg == '0)));
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scenario bench for instr_fetch: an in-order memory model with variable latency
// feeds a scoreboard of expected {pc, instr} pairs checked as decode pops them.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int              DEPTH    = 3;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst, redirect;
  logic [31:0] redirect_pc;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;
  int           lat   = 1;
  logic         rst_v = 1'b0, redirect_v = 1'b0, gnt_v = 1'b0, ready_v = 1'b0;
  logic [31:0]  rpc_v = '0;
  logic [31:0]  exp_fetch = RESET_PC;
  mreq_t        inflight[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  popped_pc[$];
  logic [31:0]  popped_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ NOP_INSTR;
  endfunction

  // One clock: drive inputs at the falling edge, check settled outputs, advance the models.
  task automatic cycle();
    mreq_t        r;
    fetch_entry_t e;
    logic         exp_req;
    @(negedge clk);
    rst             = rst_v;
    redirect        = redirect_v;
    redirect_pc     = rpc_v;
    bus.imem_gnt    = gnt_v;
    bus.instr_ready = ready_v;
    if (!rst_v && inflight.size() > 0 && inflight[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(inflight[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    #1;
    if (rst_v) begin
      tests++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: req=%b valid=%b required 0/0", bus.imem_req, bus.instr_valid);
      end
      inflight.delete();
      exp_q.delete();
      exp_fetch = RESET_PC;
    end else begin
      exp_req = !redirect_v && (inflight.size() + exp_q.size() < DEPTH);
      tests++;
      if (bus.imem_req !== exp_req) begin
        fails++;
        $display("FAIL credit_req cyc %0d: got %b required %b", cyc, bus.imem_req, exp_req);
      end
      tests++;
      if (bus.imem_addr !== exp_fetch) begin
        fails++;
        $display("FAIL imem_addr cyc %0d: got %h required %h", cyc, bus.imem_addr, exp_fetch);
      end
      tests++;
      if (bus.instr_valid !== (exp_q.size() > 0)) begin
        fails++;
        $display("FAIL instr_valid cyc %0d: got %b required %b", cyc, bus.instr_valid, exp_q.size() > 0);
      end else if (!bus.instr_valid) begin
        tests++;
        if (bus.instr !== '0 || bus.instr_pc !== '0) begin
          fails++;
          $display("FAIL idle_zero cyc %0d: instr=%h pc=%h required 0", cyc, bus.instr, bus.instr_pc);
        end
      end else if (ready_v && !redirect_v) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.instr_pc !== e.pc || bus.instr !== e.instr) begin
          fails++;
          $display("FAIL pop cyc %0d: pc=%h instr=%h required pc=%h instr=%h",
                   cyc, bus.instr_pc, bus.instr, e.pc, e.instr);
        end
        $display("[TB] pop cyc %0d pc=%h instr=%h", cyc, bus.instr_pc, bus.instr);
        popped_pc.push_back(bus.instr_pc);
        popped_instr.push_back(bus.instr);
      end
      if (bus.imem_rvalid) begin
        r = inflight.pop_front();
        if (!r.stale && !redirect_v) exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
      end
      if (redirect_v) begin
        exp_q.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        exp_fetch = {rpc_v[31:2], 2'b00};
      end else if (bus.imem_req && gnt_v) begin
        inflight.push_back('{addr: exp_fetch, due: cyc + lat, stale: 1'b0});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
  endtask

  task automatic test_reset();
    gnt_v = 1'b0; ready_v = 1'b0;
    do_reset();
    do_reset();
    cycle();
    tests++;
    if (bus.imem_addr !== RESET_PC || bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: addr=%h valid=%b required %h/0", bus.imem_addr, bus.instr_valid, RESET_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; gnt_v = 1'b1; ready_v = 1'b1;
    popped_pc.delete(); popped_instr.delete();
    repeat (2) cycle();
    tests++;
    if (popped_pc.size() !== 0) begin
      fails++;
      $display("FAIL stream_fill: pops=%0d required 0", popped_pc.size());
    end
    repeat (10) cycle();
    tests++;
    if (popped_pc.size() !== 10) begin
      fails++;
      $display("FAIL stream_rate: pops=%0d required 10", popped_pc.size());
    end else begin
      tests++;
      if (popped_pc[0] !== 32'h0 || popped_pc[1] !== 32'h4 || popped_pc[2] !== 32'h8) begin
        fails++;
        $display("FAIL stream_order: %h %h %h required 0 4 8", popped_pc[0], popped_pc[1], popped_pc[2]);
      end
    end
  endtask

  task automatic test_stall();
    ready_v = 1'b0;
    repeat (10) cycle();
    tests++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_full: req=%b valid=%b required 0/1", bus.imem_req, bus.instr_valid);
    end
    gnt_v = 1'b0; ready_v = 1'b1;
    popped_pc.delete(); popped_instr.delete();
    repeat (6) cycle();
    tests++;
    if (popped_pc.size() !== DEPTH) begin
      fails++;
      $display("FAIL stall_drain: drained=%0d required %0d", popped_pc.size(), DEPTH);
    end
  endtask

  task automatic test_gnt_hold();
    do_reset();
    lat = 1; gnt_v = 1'b1; ready_v = 1'b1;
    popped_pc.delete(); popped_instr.delete();
    repeat (2) cycle();
    gnt_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (bus.imem_addr !== 32'h8 || bus.imem_req !== 1'b1) begin
        fails++;
        $display("FAIL gnt_hold %0d: addr=%h req=%b required 00000008/1", i, bus.imem_addr, bus.imem_req);
      end
    end
    gnt_v = 1'b1;
    repeat (5) cycle();
    tests++;
    if (popped_pc.size() < 3) begin
      fails++;
      $display("FAIL gnt_resume: pops=%0d required >=3", popped_pc.size());
    end else if (popped_pc[2] !== 32'h8) begin
      fails++;
      $display("FAIL gnt_resume: third pc=%h required 00000008", popped_pc[2]);
    end
  endtask

  task automatic wait_pops(input int n, input string name);
    int budget = 30;
    while (popped_pc.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
    if (popped_pc.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: pops=%0d required %0d", name, popped_pc.size(), n);
    end
  endtask

  task automatic test_redirect_latency();
    do_reset();
    lat = 3; gnt_v = 1'b1; ready_v = 1'b1;
    repeat (2) cycle();
    redirect_v = 1'b1; rpc_v = 32'h0000_0103;
    popped_pc.delete(); popped_instr.delete();
    cycle();
    redirect_v = 1'b0;
    tests++;
    if (bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL redirect_noreq: req=%b required 0", bus.imem_req);
    end
    wait_pops(1, "redirect_latency");
    if (popped_pc.size() > 0) begin
      tests++;
      if (popped_pc[0] !== 32'h100 || popped_instr[0] !== mem_word(32'h100)) begin
        fails++;
        $display("FAIL redirect_first: pc=%h instr=%h required 00000100/%h",
                 popped_pc[0], popped_instr[0], mem_word(32'h100));
      end
    end
  endtask

  task automatic test_redirect_full();
    bit hit = 1'b0;
    lat = 1; gnt_v = 1'b1; ready_v = 1'b0;
    repeat (12) cycle();
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL full_setup: valid=%b req=%b required 1/0", bus.instr_valid, bus.imem_req);
    end
    ready_v = 1'b1; redirect_v = 1'b1; rpc_v = 32'h0000_0200;
    cycle();
    redirect_v = 1'b0;
    cycle();
    tests++;
    if (bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_flush: valid=%b required 0", bus.instr_valid);
    end
    lat = 2;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (inflight.size() == 2 && inflight[0].due <= cyc) begin
        hit = 1'b1;
        redirect_v = 1'b1; rpc_v = 32'h0000_0300;
      end
      cycle();
      redirect_v = 1'b0;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL rvalid_redirect setup: got no window required one");
    end
    popped_pc.delete(); popped_instr.delete();
    cycle();
    tests++;
    if (bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rvalid_redirect empty: valid=%b required 0", bus.instr_valid);
    end
    wait_pops(1, "rvalid_redirect");
    if (popped_pc.size() > 0) begin
      tests++;
      if (popped_pc[0] !== 32'h300) begin
        fails++;
        $display("FAIL rvalid_redirect first: pc=%h required 00000300", popped_pc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    do_reset();
    lat = 3; gnt_v = 1'b1; ready_v = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (inflight.size() == 2 && exp_q.size() > 0) hit = 1'b1;
      else cycle();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reset_mid setup: got no window required one");
    end
    do_reset();
    gnt_v = 1'b0;
    cycle();
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
      fails++;
      $display("FAIL reset_mid: valid=%b addr=%h required 0/%h", bus.instr_valid, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    lat = 1; gnt_v = 1'b1; ready_v = 1'b1;
    redirect_v = 1'b1; rpc_v = 32'hFFFF_FFFC;
    cycle();
    redirect_v = 1'b0;
    popped_pc.delete(); popped_instr.delete();
    wait_pops(2, "wrap");
    if (popped_pc.size() > 1) begin
      tests++;
      if (popped_pc[0] !== 32'hFFFF_FFFC || popped_pc[1] !== 32'h0) begin
        fails++;
        $display("FAIL wrap: pcs=%h %h required fffffffc 00000000", popped_pc[0], popped_pc[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_gnt_hold();
    test_redirect_latency();
    test_redirect_full();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
